// File: rtl/change_dispenser.sv
// Coin refund sequencer: converts a BCD dollar/tenths amount into greedy
// $2/$1/50c ejects, pacing each coin behind a hopper acknowledge and a gap.
module change_dispenser #(
    parameter int GAP_CYCLES  = 50_000_000,
    parameter int ACK_TIMEOUT = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] dollars,
    input  logic [3:0] tenths,
    input  logic       coin_ack,
    input  logic       clear_fault,
    output logic       eject_2,
    output logic       eject_1,
    output logic       eject_50,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       fault,
    output logic [4:0] remaining
);

    localparam int MAX_WAIT = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
    localparam int CW       = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        EJECT,
        WAIT_ACK,
        GAP,
        DONE,
        FAULT
    } state_t;

    state_t        state_reg, state_next;
    logic [4:0]    remaining_reg, remaining_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          error_reg, error_next;

    logic          legal;
    logic [4:0]    amount;
    logic [4:0]    coin_val;

    assign legal  = (dollars <= 4'd9) && ((tenths == 4'd0) || (tenths == 4'd5));
    assign amount = {dollars, 1'b0} + {4'b0000, (tenths == 4'd5)};

    // remaining holds steady from EJECT through WAIT_ACK, so the coin in
    // flight can be re-derived from it rather than stored separately.
    always_comb begin
        if (remaining_reg >= 5'd4)      coin_val = 5'd4;
        else if (remaining_reg >= 5'd2) coin_val = 5'd2;
        else                            coin_val = 5'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            remaining_reg <= 5'd0;
            cnt_reg       <= '0;
            error_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            cnt_reg       <= cnt_next;
            error_reg     <= error_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        cnt_next       = cnt_reg;
        error_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (!legal) begin
                        error_next = 1'b1;
                    end else begin
                        remaining_next = amount;
                        state_next     = (amount == 5'd0) ? DONE : EJECT;
                    end
                end
            end
            EJECT: begin
                cnt_next   = '0;
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                // Acknowledge takes priority over a coincident timeout.
                if (coin_ack) begin
                    remaining_next = remaining_reg - coin_val;
                    cnt_next       = '0;
                    state_next     = GAP;
                end else if (cnt_reg == ACK_LAST) begin
                    state_next = FAULT;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    cnt_next   = '0;
                    state_next = (remaining_reg != 5'd0) ? EJECT : DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            FAULT: begin
                if (clear_fault) begin
                    remaining_next = 5'd0;
                    cnt_next       = '0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign eject_2   = (state_reg == EJECT) && (coin_val == 5'd4);
    assign eject_1   = (state_reg == EJECT) && (coin_val == 5'd2);
    assign eject_50  = (state_reg == EJECT) && (coin_val == 5'd1);
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign fault     = (state_reg == FAULT);
    assign error     = error_reg;
    assign remaining = remaining_reg;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed cycle-stepped bench for change_dispenser with GAP_CYCLES=3,
// ACK_TIMEOUT=8; expected values are hand-derived from the coin schedule.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] dollars = 4'd0;
    logic [3:0] tenths = 4'd0;
    logic       coin_ack = 1'b0;
    logic       clear_fault = 1'b0;
    logic       eject_2, eject_1, eject_50;
    logic       busy, done, error, fault;
    logic [4:0] remaining;

    int n_checks = 0;
    int n_errors = 0;

    change_dispenser #(.GAP_CYCLES(3), .ACK_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dollars(dollars),
        .tenths(tenths), .coin_ack(coin_ack), .clear_fault(clear_fault),
        .eject_2(eject_2), .eject_1(eject_1), .eject_50(eject_50),
        .busy(busy), .done(done), .error(error), .fault(fault),
        .remaining(remaining)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] ej();
        return {eject_2, eject_1, eject_50};
    endfunction

    // Called in the EJECT cycle; returns positioned in the cycle after GAP.
    task automatic do_coin(input string tag, input logic [2:0] exp_ej,
                           input logic [4:0] rem_before, input logic [4:0] rem_after,
                           input bit spurious);
        check({tag, " eject"}, ej(), exp_ej);
        check({tag, " rem_eject"}, remaining, rem_before);
        tick();
        check({tag, " wait_noeject"}, ej(), 3'b000);
        tick();
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
        check({tag, " rem_ack"}, remaining, rem_after);
        check({tag, " gap_busy"}, busy, 1'b1);
        if (spurious) begin
            start = 1'b1; dollars = 4'd1; tenths = 4'd0; coin_ack = 1'b1;
        end
        tick();
        start = 1'b0; coin_ack = 1'b0;
        check({tag, " gap_noeject"}, ej(), 3'b000);
        check({tag, " gap_rem"}, remaining, rem_after);
        tick();
        check({tag, " gap3_noeject"}, ej(), 3'b000);
        tick();
    endtask

    initial begin
        #22;
        check("reset outputs", {ej(), busy, done, error, fault}, 7'd0);
        check("reset remaining", remaining, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // 3.5 dollars: $2, $1, 50c; spurious start/ack in the first gap.
        dollars = 4'd3; tenths = 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        check("r36 busy", busy, 1'b1);
        do_coin("r36 c1", 3'b100, 5'd7, 5'd3, 1'b1);
        do_coin("r36 c2", 3'b010, 5'd3, 5'd1, 1'b0);
        do_coin("r36 c3", 3'b001, 5'd1, 5'd0, 1'b0);
        check("r36 done", {done, busy, ej()}, 5'b11000);
        tick();
        check("r36 idle", {done, busy}, 2'b00);

        // Zero amount.
        dollars = 4'd0; tenths = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("r37 done", {done, busy, ej()}, 5'b11000);
        tick();
        check("r37 idle", {done, busy}, 2'b00);

        // Illegal tenths, then illegal dollars.
        dollars = 4'd2; tenths = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        check("r38 error", {error, busy, ej()}, 5'b10000);
        check("r38 rem", remaining, 5'd0);
        tick();
        check("r38 error_clear", {error, busy}, 2'b00);
        dollars = 4'd10; tenths = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("bad_dollars error", {error, busy, remaining}, {2'b10, 5'd0});
        tick();

        // Timeout into FAULT, clear with a start discarded.
        dollars = 4'd1; tenths = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("r39 eject", ej(), 3'b010);
        check("r39 rem", remaining, 5'd2);
        tick();
        for (int i = 0; i < 7; i++) tick();
        check("r39 wait8 nofault", {fault, busy}, 2'b01);
        tick();
        check("r39 fault", {fault, busy}, 2'b11);
        check("r39 fault rem", remaining, 5'd2);
        tick(); tick();
        check("r39 fault holds", {fault, ej()}, 4'b1000);
        clear_fault = 1'b1; start = 1'b1;
        tick();
        clear_fault = 1'b0; start = 1'b0;
        check("r39 cleared", {fault, busy}, 2'b00);
        check("r39 cleared rem", remaining, 5'd0);
        tick();
        check("r32 start discarded", {busy, ej()}, 4'b0000);

        // Ack on the same edge as the timeout wins.
        dollars = 4'd0; tenths = 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        check("r31 eject50", ej(), 3'b001);
        tick();
        for (int i = 0; i < 7; i++) tick();
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
        check("r31 ack wins", {fault, busy}, 2'b01);
        check("r31 rem", remaining, 5'd0);
        tick(); tick(); tick();
        check("r31 done", done, 1'b1);
        tick();

        // Reset during the second gap of a 9.5 dollar refund.
        dollars = 4'd9; tenths = 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        do_coin("r40 c1", 3'b100, 5'd19, 5'd15, 1'b0);
        check("r40 c2 eject", ej(), 3'b100);
        tick(); tick();
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
        check("r40 in gap rem", remaining, 5'd11);
        #2 rst_n = 1'b0;
        #1;
        check("r40 reset outputs", {ej(), busy, done, error, fault}, 7'd0);
        check("r40 reset rem", remaining, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            logic [2:0] seen;
            seen = 3'b000;
            for (int i = 0; i < 12; i++) begin
                tick();
                seen = seen | ej();
            end
            check("r40 no eject after reset", {seen, busy}, 4'b0000);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter GAP_CYCLES, default 50_000_000: idle clocks between successive coin ejects.
REQ-002 Parameter ACK_TIMEOUT, default 100_000_000: max clocks to wait for hopper acknowledge.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request refund of the amount on dollars/tenths.
REQ-006 dollars  input  4  refund dollars, BCD 0-9.
REQ-007 tenths  input  4  refund tenths-of-dollar digit; legal values 0 or 5 only.
REQ-008 coin_ack  input  1  hopper confirms one coin physically released.
REQ-009 clear_fault  input  1  leave FAULT state.
REQ-010 eject_2, eject_1, eject_50  output  1 each  one-cycle command to release a $2, $1 or 50c coin.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse when refund is complete.
REQ-013 error  output  1  one-cycle pulse when a start is rejected for illegal input.
REQ-014 fault  output  1  high while in FAULT.
REQ-015 remaining  output  5  outstanding refund in 50c units.

Function
REQ-016 The block SHALL implement states IDLE, EJECT, WAIT_ACK, GAP, DONE and FAULT.
REQ-017 On start=1 in IDLE with legal input, the block SHALL load remaining = dollars*2 + (tenths==5) at that edge; width 5 bits, max 19.
REQ-018 On start=1 in IDLE with dollars>9 or tenths not in {0,5}, the block SHALL pulse error for the next cycle, load nothing, and stay in IDLE.
REQ-019 A legal start with computed amount 0 SHALL go to DONE with no eject.
REQ-020 A legal start with nonzero amount SHALL go to EJECT; the selected eject line SHALL be high for exactly the next cycle.
REQ-021 Coin selection SHALL be greedy: remaining>=4 -> eject_2; else remaining>=2 -> eject_1; else eject_50.
REQ-022 At most one eject line SHALL be high in any cycle.
REQ-023 After EJECT the block SHALL enter WAIT_ACK and count clocks from 0.
REQ-024 coin_ack=1 sampled in WAIT_ACK SHALL subtract the ejected value (4, 2 or 1) from remaining at that edge and enter GAP.
REQ-025 GAP SHALL last exactly GAP_CYCLES clocks, then go to EJECT if remaining>0, else to DONE.
REQ-026 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-027 If the WAIT_ACK count reaches ACK_TIMEOUT without coin_ack, the block SHALL enter FAULT with remaining unchanged.
REQ-028 In FAULT, fault and busy SHALL stay high; clear_fault=1 SHALL return to IDLE and zero remaining.
REQ-029 start SHALL be ignored in every state except IDLE.
REQ-030 coin_ack SHALL be ignored outside WAIT_ACK.
REQ-031 If coin_ack and the timeout both occur on the same edge, coin_ack SHALL win.
REQ-032 If start and clear_fault are both high in FAULT, only clear_fault SHALL act; the start is discarded.

Reset
REQ-033 While rst_n=0, the block SHALL be held in IDLE with all outputs 0, remaining=0 and all counters 0.
REQ-034 Reset asserted mid-refund SHALL abort the refund immediately; no eject pulse SHALL follow it.
REQ-035 The first start SHALL be accepted on the first rising edge with rst_n=1.

Verification (GAP_CYCLES=3, ACK_TIMEOUT=8)
REQ-036 dollars=3, tenths=5, start, coin_ack 2 cycles after each eject -> eject_2, then eject_1, then eject_50; remaining goes 7->3->1->0; done pulses once; busy then drops.
REQ-037 dollars=0, tenths=0, start -> done pulses on the next cycle, no eject, busy high for exactly one cycle.
REQ-038 dollars=2, tenths=3, start -> error pulses for one cycle, no eject, busy stays 0, remaining stays 0.
REQ-039 dollars=1, tenths=0, start, coin_ack withheld -> eject_1 pulses once; after 8 WAIT_ACK cycles fault=1 and remaining=2; clear_fault -> IDLE with remaining=0.
REQ-040 dollars=9, tenths=5, start, then rst_n=0 during the second GAP -> all outputs 0 at once; after release no eject until a new start.
REQ-041 A start pulse and a spurious coin_ack during GAP of an active refund -> both ignored; coin sequence and remaining are unchanged.
